exc_sequencer: RTL and testbench

Sequences precise exception, interrupt and ERET entry for the five-stage MIPS pipeline. It sits between the MEM-stage exception sources, the victim-instruction detector in ID and the CP0 register file. On an event it captures the victim context, holds a pipeline flush for a fixed number of cycles, then issues one commit cycle that writes EPC/Cause/Status/BadVAddr and redirects the PC.

---
 rtl/exc_sequencer_if.sv | 38 +++
 rtl/exc_sequencer.sv | 91 +++++++++
 tb/tb_exc_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: event, victim-context and CP0-write signals between the pipeline and the exception sequencer.
interface exc_sequencer_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        int_pending;
  logic        status_exl;
  logic        eret_valid;
  logic [31:0] epc_value;
  logic [31:0] vic_inst_addr;
  logic        vic_is_delayslot;
  logic        busy;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic        cause_we;
  logic        cause_bd;
  logic [4:0]  cause_exccode;
  logic        badvaddr_we;
  logic [31:0] badvaddr_wdata;
  logic        set_exl;
  logic        clr_exl;
  modport master (
    output exc_valid, exc_code, exc_badvaddr_valid, exc_badvaddr, int_pending, status_exl,
           eret_valid, epc_value, vic_inst_addr, vic_is_delayslot,
    input  busy, flush, pc_redirect, redirect_target, epc_we, epc_wdata, cause_we, cause_bd,
           cause_exccode, badvaddr_we, badvaddr_wdata, set_exl, clr_exl
  );
  modport slave (
    input  exc_valid, exc_code, exc_badvaddr_valid, exc_badvaddr, int_pending, status_exl,
           eret_valid, epc_value, vic_inst_addr, vic_is_delayslot,
    output busy, flush, pc_redirect, redirect_target, epc_we, epc_wdata, cause_we, cause_bd,
           cause_exccode, badvaddr_we, badvaddr_wdata, set_exl, clr_exl
  );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer: captures an exception/interrupt/ERET, holds flush for a fixed time, then issues one CP0 commit and PC redirect.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  exc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_ERET} kind_t;
  state_t      r_state, w_nstate;
  kind_t       r_kind, w_kind;
  logic [2:0]  r_cnt, w_ncnt;
  logic        w_int, w_ev, w_commit;
  logic [4:0]  r_code;
  logic        r_bad_v, r_bd;
  logic [31:0] r_bad, r_epc, r_tgt;
  logic        r_flush, r_redir, r_epc_we, r_cause_we, r_bad_we, r_set_exl, r_clr_exl;
  always_comb begin
    w_int    = bus.int_pending & ~bus.status_exl;
    w_ev     = bus.exc_valid | w_int | bus.eret_valid;
    w_kind   = bus.exc_valid ? K_EXC : (w_int ? K_INT : K_ERET);
    w_nstate = (r_state == IDLE)  ? (w_ev ? FLUSH : IDLE) :
               (r_state == FLUSH) ? ((r_cnt == 3'd0) ? COMMIT : FLUSH) : IDLE;
    w_ncnt   = (r_state == IDLE) ? 3'(FLUSH_CYCLES - 1) :
               ((r_state == FLUSH) && (r_cnt != 3'd0)) ? r_cnt - 3'd1 : r_cnt;
    w_commit = (w_nstate == COMMIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end
  // Strobes are registered from the next state so COMMIT sees them without an input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush    <= 1'b0;
      r_redir    <= 1'b0;
      r_epc_we   <= 1'b0;
      r_cause_we <= 1'b0;
      r_bad_we   <= 1'b0;
      r_set_exl  <= 1'b0;
      r_clr_exl  <= 1'b0;
    end else begin
      r_flush    <= (w_nstate != IDLE);
      r_redir    <= w_commit;
      r_epc_we   <= w_commit && (r_kind != K_ERET);
      r_cause_we <= w_commit && (r_kind != K_ERET);
      r_bad_we   <= w_commit && (r_kind == K_EXC) && r_bad_v;
      r_set_exl  <= w_commit && (r_kind != K_ERET);
      r_clr_exl  <= w_commit && (r_kind == K_ERET);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind  <= K_EXC;
      r_code  <= 5'd0;
      r_bad_v <= 1'b0;
      r_bad   <= 32'd0;
      r_bd    <= 1'b0;
      r_epc   <= 32'd0;
      r_tgt   <= 32'd0;
    end else if ((r_state == IDLE) && w_ev) begin
      r_kind  <= w_kind;
      r_code  <= bus.exc_valid ? bus.exc_code : 5'd0;
      r_bad_v <= bus.exc_badvaddr_valid;
      r_bad   <= bus.exc_badvaddr;
      r_bd    <= bus.vic_is_delayslot;
      r_epc   <= bus.vic_is_delayslot ? bus.vic_inst_addr - 32'd4 : bus.vic_inst_addr;
      r_tgt   <= (w_kind == K_ERET) ? bus.epc_value : HANDLER_ADDR;
    end
  end
  assign bus.busy            = (r_state != IDLE);
  assign bus.flush           = r_flush;
  assign bus.pc_redirect     = r_redir;
  assign bus.redirect_target = r_tgt;
  assign bus.epc_we          = r_epc_we;
  assign bus.epc_wdata       = r_epc;
  assign bus.cause_we        = r_cause_we;
  assign bus.cause_bd        = r_bd;
  assign bus.cause_exccode   = r_code;
  assign bus.badvaddr_we     = r_bad_we;
  assign bus.badvaddr_wdata  = r_bad;
  assign bus.set_exl         = r_set_exl;
  assign bus.clr_exl         = r_clr_exl;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed and randomized events checked against a per-event reference of the commit record.
module tb_exc_sequencer;
  localparam int          F       = 2;
  localparam logic [31:0] HANDLER = 32'hBFC00380;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exc_sequencer_if bus();
  exc_sequencer #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle(input logic exl);
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_badvaddr_valid = 0; bus.exc_badvaddr = 0;
    bus.int_pending = 0; bus.status_exl = exl; bus.eret_valid = 0; bus.epc_value = 0;
    bus.vic_inst_addr = 0; bus.vic_is_delayslot = 0;
  endtask

  task automatic set_random();
    bus.exc_valid = 1'($urandom); bus.exc_code = 5'($urandom); bus.exc_badvaddr_valid = 1'($urandom);
    bus.exc_badvaddr = $urandom; bus.int_pending = 1'($urandom); bus.status_exl = 1'($urandom);
    bus.eret_valid = 1'($urandom); bus.epc_value = $urandom; bus.vic_inst_addr = $urandom;
    bus.vic_is_delayslot = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".flush"}, bus.flush, 0);
    chk({tag, ".redirect"}, bus.pc_redirect, 0);
    chk({tag, ".target"}, bus.redirect_target, 0);
    chk({tag, ".strobes"}, {bus.epc_we, bus.cause_we, bus.badvaddr_we, bus.set_exl, bus.clr_exl}, 0);
    chk({tag, ".epc"}, bus.epc_wdata, 0);
    chk({tag, ".cause"}, {bus.cause_bd, bus.cause_exccode}, 0);
    chk({tag, ".badvaddr"}, bus.badvaddr_wdata, 0);
  endtask

  // One event: reference derives the winner and commit record from the priority and EPC rules.
  task automatic run_event(input string tag, input logic exc, input logic [4:0] code, input logic bv,
                           input logic [31:0] bad, input logic intp, input logic exl, input logic eret,
                           input logic [31:0] epcv, input logic [31:0] vic, input logic bd, input bit hold_int);
    int          kind;
    logic        cm, trap;
    logic [31:0] exp_epc, exp_tgt;
    kind    = exc ? 0 : (intp && !exl) ? 1 : eret ? 2 : 3;
    trap    = (kind == 0) || (kind == 1);
    exp_epc = bd ? vic - 32'd4 : vic;
    exp_tgt = (kind == 2) ? epcv : HANDLER;
    @(negedge clk);
    bus.exc_valid = exc; bus.exc_code = code; bus.exc_badvaddr_valid = bv; bus.exc_badvaddr = bad;
    bus.int_pending = intp; bus.status_exl = exl; bus.eret_valid = eret; bus.epc_value = epcv;
    bus.vic_inst_addr = vic; bus.vic_is_delayslot = bd;
    for (int k = 1; k <= F + 1; k++) begin
      @(negedge clk);
      cm = (k == F + 1);
      chk({tag, ".flush"}, bus.flush, 1);
      chk({tag, ".busy"}, bus.busy, 1);
      chk({tag, ".redirect"}, bus.pc_redirect, cm);
      chk({tag, ".epc_we"}, bus.epc_we, cm && trap);
      chk({tag, ".cause_we"}, bus.cause_we, cm && trap);
      chk({tag, ".set_exl"}, bus.set_exl, cm && trap);
      chk({tag, ".clr_exl"}, bus.clr_exl, cm && kind == 2);
      chk({tag, ".badvaddr_we"}, bus.badvaddr_we, cm && kind == 0 && bv);
      if (cm) begin
        chk({tag, ".target"}, bus.redirect_target, exp_tgt);
        if (trap) begin
          chk({tag, ".epc_wdata"}, bus.epc_wdata, exp_epc);
          chk({tag, ".cause_bd"}, bus.cause_bd, bd);
          chk({tag, ".exccode"}, bus.cause_exccode, (kind == 0) ? code : 5'd0);
        end
        if (kind == 0 && bv) chk({tag, ".badvaddr"}, bus.badvaddr_wdata, bad);
      end
      if (hold_int) begin
        set_idle(cm);
        bus.int_pending = 1;
      end else if (cm) set_idle(0);
      else set_random();
    end
    @(negedge clk);
    chk({tag, ".idle_busy"}, bus.busy, 0);
    chk({tag, ".idle_flush"}, bus.flush, 0);
  endtask

  initial begin
    logic e, ip, x, er;
    set_idle(0);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_all_zero("post_reset");
    run_event("exc_adel", 1, 5'h04, 1, 32'h00401003, 0, 0, 0, 0, 32'hBFC00100, 0, 0);
    run_event("int_ds", 0, 5'h1F, 1, 32'h12345678, 1, 0, 0, 0, 32'hBFC00208, 1, 0);
    run_event("all_three", 1, 5'h0C, 0, 0, 1, 0, 1, 32'hBFC00400, 32'h80001000, 0, 0);
    @(negedge clk);
    chk("single_commit", bus.pc_redirect, 0);
    run_event("eret", 0, 0, 0, 0, 0, 0, 1, 32'hBFC00400, 32'h80000000, 0, 0);
    run_event("eret_masked_int", 0, 0, 0, 0, 1, 1, 1, 32'h00400010, 32'h1, 1, 0);
    run_event("epc_wrap", 1, 5'h0A, 0, 0, 0, 0, 0, 0, 32'h00000000, 1, 0);
    run_event("int_hold", 0, 0, 0, 0, 1, 0, 0, 0, 32'hBFC00300, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("int_masked_busy", bus.busy, 0);
      chk("int_masked_redirect", bus.pc_redirect, 0);
    end
    set_idle(0);
    for (int i = 0; i < 16; i++) begin
      e = 1'($urandom); ip = 1'($urandom); x = 1'($urandom); er = 1'($urandom);
      if (!e && !(ip && !x)) er = 1;
      run_event("rand", e, 5'($urandom), 1'($urandom), $urandom, ip, x, er, $urandom, $urandom, 1'($urandom), 0);
    end
    @(negedge clk);
    bus.exc_valid = 1; bus.exc_code = 5'h05; bus.exc_badvaddr_valid = 1; bus.exc_badvaddr = 32'hDEAD0001;
    bus.vic_inst_addr = 32'hBFC00500;
    @(negedge clk);
    chk("rst_flush_pre", bus.flush, 1);
    set_idle(0);
    #3 rst_n = 0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("after_rst_redirect", bus.pc_redirect, 0);
      chk("after_rst_busy", bus.busy, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not reach the summary in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
